decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have port: code_group_10b  input  10  received code group {a,b,c,d,e,i,f,g,h,j}, bit 9 = a, sampled every clk edge.
REQ-004 The block SHALL have port: code_group_8b  output  8  decoded octet {H,G,F,E,D,C,B,A}, bit 0 = A.
REQ-005 The block SHALL have port: is_k  output  1  decoded group is a valid control (Kxx.y) character.
REQ-006 The block SHALL have port: running_disparity  output  1  current receive RD, 0 = negative, 1 = positive.
REQ-007 The block SHALL have port: code_error  output  1  group absent from both RD columns of the 8b/10b table.
REQ-008 The block SHALL have port: disparity_error  output  1  valid group received in the wrong RD column.
REQ-009 The block SHALL have port: sync_status  output  1  comma synchronization acquired.
REQ-010 The block SHALL have port: err_count  output  16  saturating count of code_error or disparity_error events.

Function
REQ-011 The block SHALL register all outputs; latency is exactly 1 clk from sampling code_group_10b to the corresponding outputs.
REQ-012 The block SHALL decode all 256 Dx.y and the 12 standard Kxx.y groups in both RD columns, including the D.x.7 alternate (A7) forms.
REQ-013 The block SHALL update running_disparity per sub-block (6b then 4b): +2 ones-excess sets positive, -2 sets negative, balanced keeps the previous value.
REQ-014 The block SHALL assert disparity_error for 1 cycle on a table-valid group whose 6b or 4b sub-block polarity conflicts with the current RD; decoded data is still output and RD is updated from the received group.
REQ-015 On code_error, the block SHALL output code_group_8b = 8'h00 and is_k = 0, leave running_disparity unchanged, and hold disparity_error low.
REQ-016 The block SHALL implement a sync FSM with states LOSS_OF_SYNC, COMMA_1, COMMA_2, SYNC_OK; sync_status = 1 only in SYNC_OK.
REQ-017 From LOSS_OF_SYNC, COMMA_1, or COMMA_2, a valid K28.5 SHALL advance one state; any error SHALL return to LOSS_OF_SYNC; other valid groups SHALL hold the state.
REQ-018 In SYNC_OK, a 3-bit bad counter SHALL increment on each error and clear after 4 consecutive error-free groups; reaching 4 SHALL enter LOSS_OF_SYNC and clear the counter.
REQ-019 If an error and the 4th consecutive good group would coincide, the block SHALL give priority to the error.
REQ-020 err_count SHALL increment by 1 per group flagged with code_error or disparity_error, and SHALL saturate at 16'hFFFF without wrapping.

Reset
REQ-021 While reset is high, the block SHALL output: code_group_8b = 8'h00, is_k = 0, running_disparity = 0 (negative), code_error = 0, disparity_error = 0, sync_status = 0 (FSM in LOSS_OF_SYNC, bad counter 0), err_count = 0.
REQ-022 On reset assertion mid-stream, the block SHALL take effect immediately without waiting for clk; the first group sampled after deassertion SHALL be decoded against RD negative.

Configuration
REQ-023 With DECODE_ERR_CNT_EN defined, the block SHALL implement err_count per REQ-020.
REQ-024 Without DECODE_ERR_CNT_EN, the block SHALL keep the err_count port with no counter logic and SHALL drive it to constant 16'h0000; all other behaviour SHALL be unchanged.

Verification
REQ-025 The bench SHALL check: after reset, 10'b1001110100 (D0.0, RD-) -> code_group_8b = 8'h00, is_k = 0, running_disparity = 0, no errors, one cycle later.
REQ-026 The bench SHALL check: 10'b0011111010 (K28.5, RD-) -> 8'hBC, is_k = 1, running_disparity = 1; a following 10'b0110001011 (D0.0, RD+) -> 8'h00, running_disparity = 1.
REQ-027 The bench SHALL check: from reset, 10'b0110001011 (RD+ form while RD-) -> disparity_error = 1 for 1 cycle, 8'h00 output, err_count = 1 (macro defined).
REQ-028 The bench SHALL check: 10'b0000000000 -> code_error = 1, code_group_8b = 8'h00, running_disparity unchanged, err_count incremented.
REQ-029 The bench SHALL check: three K28.5 groups with correct alternating RD -> sync_status = 1 one cycle after the third; then 4 invalid groups -> sync_status = 0 after the 4th; 3 invalid groups followed by 4 valid groups -> sync_status stays 1.
REQ-030 The bench SHALL check: reset asserted between clk edges mid-stream -> all outputs reach reset values before the next edge; without DECODE_ERR_CNT_EN, err_count = 0 throughout all scenarios.

Source files
------------

// File: rtl/decode_if.sv
// decode_if: code-group in / decoded octet and status out for decode.
// master drives code_group_10b; slave (decode) drives the result fields.
interface decode_if;
   logic [9:0]  code_group_10b;
   logic [7:0]  code_group_8b;
   logic        is_k;
   logic        running_disparity;
   logic        code_error;
   logic        disparity_error;
   logic        sync_status;
   logic [15:0] err_count;

   modport master (
      output code_group_10b,
      input  code_group_8b, is_k, running_disparity,
      input  code_error, disparity_error, sync_status, err_count
   );

   modport slave (
      input  code_group_10b,
      output code_group_8b, is_k, running_disparity,
      output code_error, disparity_error, sync_status, err_count
   );
endinterface

// File: rtl/decode.sv
// decode: registered 8b/10b decoder with RD tracking and comma sync FSM.
// Ports: clk, reset (async, active-high), bus (decode_if.slave):
//   code_group_10b {a..j} in; code_group_8b, is_k, running_disparity,
//   code_error, disparity_error, sync_status, err_count out (1 clk latency).
// Option: DECODE_ERR_CNT_EN enables the saturating err_count, else 0.
module decode (
   input  logic     clk,
   input  logic     reset,
   decode_if.slave  bus
);

   typedef enum logic [1:0] {
      LOSS_OF_SYNC,
      COMMA_1,
      COMMA_2,
      SYNC_OK
   } state_t;

   // 6b lookup: {valid RD-, valid RD+, K28, x[4:0]}
   function automatic logic [7:0] f6(input logic [5:0] c);
      logic [7:0] r;
      r = 8'h00;
      case (c)
         6'b100111: r = {3'b100, 5'd0};
         6'b011000: r = {3'b010, 5'd0};
         6'b011101: r = {3'b100, 5'd1};
         6'b100010: r = {3'b010, 5'd1};
         6'b101101: r = {3'b100, 5'd2};
         6'b010010: r = {3'b010, 5'd2};
         6'b110001: r = {3'b110, 5'd3};
         6'b110101: r = {3'b100, 5'd4};
         6'b001010: r = {3'b010, 5'd4};
         6'b101001: r = {3'b110, 5'd5};
         6'b011001: r = {3'b110, 5'd6};
         6'b111000: r = {3'b100, 5'd7};
         6'b000111: r = {3'b010, 5'd7};
         6'b111001: r = {3'b100, 5'd8};
         6'b000110: r = {3'b010, 5'd8};
         6'b100101: r = {3'b110, 5'd9};
         6'b010101: r = {3'b110, 5'd10};
         6'b110100: r = {3'b110, 5'd11};
         6'b001101: r = {3'b110, 5'd12};
         6'b101100: r = {3'b110, 5'd13};
         6'b011100: r = {3'b110, 5'd14};
         6'b010111: r = {3'b100, 5'd15};
         6'b101000: r = {3'b010, 5'd15};
         6'b011011: r = {3'b100, 5'd16};
         6'b100100: r = {3'b010, 5'd16};
         6'b100011: r = {3'b110, 5'd17};
         6'b010011: r = {3'b110, 5'd18};
         6'b110010: r = {3'b110, 5'd19};
         6'b001011: r = {3'b110, 5'd20};
         6'b101010: r = {3'b110, 5'd21};
         6'b011010: r = {3'b110, 5'd22};
         6'b111010: r = {3'b100, 5'd23};
         6'b000101: r = {3'b010, 5'd23};
         6'b110011: r = {3'b100, 5'd24};
         6'b001100: r = {3'b010, 5'd24};
         6'b100110: r = {3'b110, 5'd25};
         6'b010110: r = {3'b110, 5'd26};
         6'b110110: r = {3'b100, 5'd27};
         6'b001001: r = {3'b010, 5'd27};
         6'b001110: r = {3'b110, 5'd28};
         6'b101110: r = {3'b100, 5'd29};
         6'b010001: r = {3'b010, 5'd29};
         6'b011110: r = {3'b100, 5'd30};
         6'b100001: r = {3'b010, 5'd30};
         6'b101011: r = {3'b100, 5'd31};
         6'b010100: r = {3'b010, 5'd31};
         6'b001111: r = {3'b101, 5'd28};
         6'b110000: r = {3'b011, 5'd28};
         default:   r = 8'h00;
      endcase
      return r;
   endfunction

   // 4b lookup: {valid RD-, valid RD+, P7, A7, y[2:0]}
   function automatic logic [6:0] f4(input logic [3:0] c);
      logic [6:0] r;
      r = 7'h00;
      case (c)
         4'b1011: r = {4'b1000, 3'd0};
         4'b0100: r = {4'b0100, 3'd0};
         4'b1001: r = {4'b1100, 3'd1};
         4'b0101: r = {4'b1100, 3'd2};
         4'b1100: r = {4'b1000, 3'd3};
         4'b0011: r = {4'b0100, 3'd3};
         4'b1101: r = {4'b1000, 3'd4};
         4'b0010: r = {4'b0100, 3'd4};
         4'b1010: r = {4'b1100, 3'd5};
         4'b0110: r = {4'b1100, 3'd6};
         4'b1110: r = {4'b1010, 3'd7};
         4'b0001: r = {4'b0110, 3'd7};
         4'b0111: r = {4'b1001, 3'd7};
         4'b1000: r = {4'b0101, 3'd7};
         default: r = 7'h00;
      endcase
      return r;
   endfunction

   // Is the group a legal table entry when received with start RD = col?
   // The 4b half is checked in the column left behind by the 6b half.
   function automatic logic col_ok(
      input logic       col,
      input logic [7:0] s6,
      input logic [6:0] s4,
      input logic       bal6,
      input logic       pos6,
      input logic       kalt
   );
      logic       mid, v6, v4, a7d;
      logic [4:0] x;
      x   = s6[4:0];
      mid = bal6 ? col : pos6;
      v6  = col ? s6[6] : s6[7];
      v4  = mid ? s4[5] : s4[6];
      // A7 replaces P7 for data where P7 would give a run of five
      a7d = mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                : (x == 5'd17 || x == 5'd18 || x == 5'd20);
      if (s6[5])
         return v6 && v4 && !s4[4];
      else if (s4[4])
         return v6 && v4 && !a7d;
      else if (s4[3])
         return v6 && v4 && (a7d || kalt);
      else
         return v6 && v4;
   endfunction

   logic [7:0]  w_s6;
   logic [6:0]  w_s4;
   logic [2:0]  w_n6, w_n4;
   logic        w_bal6, w_pos6, w_bal4, w_pos4;
   logic        w_k28, w_kalt, w_isk;
   logic [4:0]  w_x;
   logic [2:0]  w_yraw, w_y;
   logic        w_ok_n, w_ok_p;
   logic        w_cerr, w_derr, w_err, w_comma;
   logic        w_mid, w_rd_nxt;
   logic [7:0]  w_data;

   logic [7:0]  r_data;
   logic        r_k, r_rd, r_cerr, r_derr;
   state_t      r_state, w_state_nxt;
   logic [2:0]  r_bad, w_bad_nxt;
   logic [1:0]  r_good, w_good_nxt;

   always_comb begin
      w_n6 = 3'd0;
      w_n4 = 3'd0;
      for (int i = 4; i < 10; i++)
         w_n6 = w_n6 + {2'b00, bus.code_group_10b[i]};
      for (int i = 0; i < 4; i++)
         w_n4 = w_n4 + {2'b00, bus.code_group_10b[i]};
   end

   assign w_s6   = f6(bus.code_group_10b[9:4]);
   assign w_s4   = f4(bus.code_group_10b[3:0]);
   assign w_bal6 = (w_n6 == 3'd3);
   assign w_pos6 = (w_n6 > 3'd3);
   assign w_bal4 = (w_n4 == 3'd2);
   assign w_pos4 = (w_n4 > 3'd2);
   assign w_k28  = w_s6[5];
   assign w_x    = w_s6[4:0];
   assign w_yraw = w_s4[2:0];

   assign w_kalt = !w_k28 && (w_x == 5'd23 || w_x == 5'd27 ||
                              w_x == 5'd29 || w_x == 5'd30);
   assign w_isk  = w_k28 || (w_s4[3] && w_kalt);

   // K28 from RD+ is the full complement of the RD- form, so its
   // neutral 4b codes read as y and 7-y swapped against the D table.
   assign w_y = (w_k28 && !w_pos6 &&
                 (w_yraw == 3'd1 || w_yraw == 3'd2 ||
                  w_yraw == 3'd5 || w_yraw == 3'd6)) ? ~w_yraw : w_yraw;

   assign w_ok_n = col_ok(1'b0, w_s6, w_s4, w_bal6, w_pos6, w_kalt);
   assign w_ok_p = col_ok(1'b1, w_s6, w_s4, w_bal6, w_pos6, w_kalt);

   assign w_cerr  = !(w_ok_n || w_ok_p);
   assign w_derr  = !w_cerr && !(r_rd ? w_ok_p : w_ok_n);
   assign w_err   = w_cerr || w_derr;
   assign w_comma = !w_err && w_k28 && (w_y == 3'd5);

   assign w_mid    = w_bal6 ? r_rd : w_pos6;
   assign w_rd_nxt = w_cerr ? r_rd : (w_bal4 ? w_mid : w_pos4);
   assign w_data   = w_cerr ? 8'h00 : {w_y, w_x};

   always_comb begin
      w_state_nxt = r_state;
      w_bad_nxt   = r_bad;
      w_good_nxt  = r_good;
      unique case (r_state)
         LOSS_OF_SYNC: begin
            if (w_comma) w_state_nxt = COMMA_1;
         end
         COMMA_1: begin
            if (w_err)        w_state_nxt = LOSS_OF_SYNC;
            else if (w_comma) w_state_nxt = COMMA_2;
         end
         COMMA_2: begin
            if (w_err) begin
               w_state_nxt = LOSS_OF_SYNC;
            end else if (w_comma) begin
               w_state_nxt = SYNC_OK;
               w_bad_nxt   = 3'd0;
               w_good_nxt  = 2'd0;
            end
         end
         SYNC_OK: begin
            // error is tested first so it wins over a 4th good group
            if (w_err) begin
               w_good_nxt = 2'd0;
               if (r_bad == 3'd3) begin
                  w_state_nxt = LOSS_OF_SYNC;
                  w_bad_nxt   = 3'd0;
               end else begin
                  w_bad_nxt = r_bad + 3'd1;
               end
            end else if (r_good == 2'd3) begin
               w_good_nxt = 2'd0;
               w_bad_nxt  = 3'd0;
            end else begin
               w_good_nxt = r_good + 2'd1;
            end
         end
         default: w_state_nxt = LOSS_OF_SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data  <= 8'h00;
         r_k     <= 1'b0;
         r_rd    <= 1'b0;
         r_cerr  <= 1'b0;
         r_derr  <= 1'b0;
         r_state <= LOSS_OF_SYNC;
         r_bad   <= 3'd0;
         r_good  <= 2'd0;
      end else begin
         r_data  <= w_data;
         r_k     <= !w_cerr && w_isk;
         r_rd    <= w_rd_nxt;
         r_cerr  <= w_cerr;
         r_derr  <= w_derr;
         r_state <= w_state_nxt;
         r_bad   <= w_bad_nxt;
         r_good  <= w_good_nxt;
      end
   end

`ifdef DECODE_ERR_CNT_EN
   logic [15:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= 16'h0000;
      else if (w_err && r_cnt != 16'hFFFF)
         r_cnt <= r_cnt + 16'h0001;
   end

   assign bus.err_count = r_cnt;
`else
   assign bus.err_count = 16'h0000;
`endif

   assign bus.code_group_8b     = r_data;
   assign bus.is_k              = r_k;
   assign bus.running_disparity = r_rd;
   assign bus.code_error        = r_cerr;
   assign bus.disparity_error   = r_derr;
   assign bus.sync_status       = (r_state == SYNC_OK);

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed scoreboard bench for the 8b/10b decode block.
// Expectations are queued at drive time and checked one clock later.
module tb_decode;

   logic clk;
   logic reset;
   decode_if bus ();

   decode dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [7:0]  d;
      logic        k, rd, ce, de, ss;
      logic [15:0] ec;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp;
   int          n_bad;
   int          n_step;
   logic [15:0] m_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s step %0d: got %h want %h", tag, n_step, obs, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_d",  {8'h0, bus.code_group_8b}, 16'h0);
      chk("rst_k",  {15'h0, bus.is_k}, 16'h0);
      chk("rst_rd", {15'h0, bus.running_disparity}, 16'h0);
      chk("rst_ce", {15'h0, bus.code_error}, 16'h0);
      chk("rst_de", {15'h0, bus.disparity_error}, 16'h0);
      chk("rst_ss", {15'h0, bus.sync_status}, 16'h0);
      chk("rst_ec", bus.err_count, 16'h0);
   endtask

   // called at a negedge; returns at the following negedge
   task automatic step(input logic [9:0] cg, input logic [7:0] d,
                       input logic k, input logic rd, input logic ce,
                       input logic de, input logic ss);
      exp_t e;
      n_step++;
      bus.code_group_10b = cg;
`ifdef DECODE_ERR_CNT_EN
      if ((ce || de) && m_err != 16'hFFFF) m_err = m_err + 16'h1;
`endif
      e.d = d; e.k = k; e.rd = rd; e.ce = ce; e.de = de; e.ss = ss;
      e.ec = m_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      n_cmp++;
      assert (sb.size() > 0) else begin
         n_bad++;
         $error("FAIL sb_empty step %0d: got 0 want 1", n_step);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("data", {8'h0, bus.code_group_8b}, {8'h0, e.d});
         chk("is_k", {15'h0, bus.is_k}, {15'h0, e.k});
         chk("rd",   {15'h0, bus.running_disparity}, {15'h0, e.rd});
         chk("cerr", {15'h0, bus.code_error}, {15'h0, e.ce});
         chk("derr", {15'h0, bus.disparity_error}, {15'h0, e.de});
         chk("sync", {15'h0, bus.sync_status}, {15'h0, e.ss});
         chk("ecnt", bus.err_count, e.ec);
      end
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      n_step = 0;
      m_err = 16'h0;
      reset = 1'b1;
      bus.code_group_10b = 10'h000;
      repeat (2) @(posedge clk);
      #1;
      chk_reset();
      @(negedge clk);
      reset = 1'b0;

      // basic decode and RD tracking, sync acquired on 3rd comma
      step(10'b1001110100, 8'h00, 0, 0, 0, 0, 0);
      step(10'b0011111010, 8'hBC, 1, 1, 0, 0, 0);
      step(10'b0110001011, 8'h00, 0, 1, 0, 0, 0);
      step(10'b1100000101, 8'hBC, 1, 0, 0, 0, 0);
      step(10'b0011111010, 8'hBC, 1, 1, 0, 0, 1);

      // four code errors drop sync; RD held
      step(10'b0000000000, 8'h00, 0, 1, 1, 0, 1);
      step(10'b0000000000, 8'h00, 0, 1, 1, 0, 1);
      step(10'b0000000000, 8'h00, 0, 1, 1, 0, 1);
      step(10'b0000000000, 8'h00, 0, 1, 1, 0, 0);

      // re-sync from RD+
      step(10'b1100000101, 8'hBC, 1, 0, 0, 0, 0);
      step(10'b0011111010, 8'hBC, 1, 1, 0, 0, 0);
      step(10'b1100000101, 8'hBC, 1, 0, 0, 0, 1);

      // 3 errors then 4 good: bad counter clears, sync kept
      for (int i = 0; i < 3; i++)
         step(10'b0000000000, 8'h00, 0, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++)
         step(10'b1001110100, 8'h00, 0, 0, 0, 0, 1);
      step(10'b0000000000, 8'h00, 0, 0, 1, 0, 1);

      // disparity error still decodes and moves RD
      step(10'b0110001011, 8'h00, 0, 1, 0, 1, 1);

      // P7/A7 forms and K.x.7
      step(10'b1000110001, 8'hF1, 0, 0, 0, 0, 1);
      step(10'b1000110111, 8'hF1, 0, 1, 0, 0, 1);
      step(10'b1100000111, 8'hFC, 1, 1, 0, 0, 1);
      step(10'b0001010111, 8'hF7, 1, 1, 0, 0, 1);
      step(10'b0011110001, 8'h00, 0, 1, 1, 0, 1);
      step(10'b0001110100, 8'h07, 0, 0, 0, 0, 1);
      step(10'b1100011100, 8'h63, 0, 0, 0, 0, 1);
      step(10'b1101001110, 8'hEB, 0, 1, 0, 0, 1);
      step(10'b1101001000, 8'hEB, 0, 0, 0, 0, 1);
      step(10'b1101000001, 8'h00, 0, 0, 1, 0, 1);

      // reset between clock edges mid-stream
      step(10'b0011111010, 8'hBC, 1, 1, 0, 0, 1);
      #2;
      reset = 1'b1;
      sb.delete();
      m_err = 16'h0;
      #1;
      chk_reset();
      @(negedge clk);
      reset = 1'b0;
      step(10'b0110001011, 8'h00, 0, 1, 0, 1, 0);

`ifdef DECODE_ERR_CNT_EN
      bus.code_group_10b = 10'h000;
      repeat (65540) @(posedge clk);
      #1;
      chk("ecnt_sat", bus.err_count, 16'hFFFF);
      m_err = 16'hFFFF;
      @(negedge clk);
`endif
      step(10'b0000000000, 8'h00, 0, 1, 1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
